// File: rtl/efuse_pkg.sv
// Shared types and sizes for the eFuse macro responder model.
package efuse_pkg;

  localparam int EFUSE_NBITS  = 256;
  localparam int EFUSE_NBYTES = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    PG      = 2'd2,
    WAIT_LO = 2'd3
  } efuse_emu_st_e;

  // Byte idx of the fuse array; byte 0 is fuse bits [7:0].
  function automatic logic [7:0] fuse_byte(input logic [EFUSE_NBITS-1:0] fuse,
                                           input logic [4:0]             idx);
    return fuse[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/efuse_emu_tchk.sv
// Pulse-width and address-stability checker for the eFuse responder.
// Only built when EFUSE_EMU_TCHK_EN is defined.
`ifdef EFUSE_EMU_TCHK_EN
module efuse_emu_tchk
  import efuse_pkg::*;
#(
  parameter int TRD_MIN  = 2,
  parameter int TPGM_MIN = 10,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aen_i,
  input  logic [7:0]       addr_i,
  input  efuse_emu_st_e    state_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             err_clr_i,
  output logic             short_o,
  output logic             addr_chg_o,
  output logic [7:0]       viol_cnt_o
);

  logic       aen_q;
  logic [7:0] addr_q;
  logic [7:0] viol_q;
  logic [8:0] viol_sum;

  // Short pulse: aen falls while the counter is below the mode's minimum.
  always_comb begin
    short_o = 1'b0;
    if (!aen_i) begin
      if (state_i == RD && cnt_i < CNT_W'(TRD_MIN))
        short_o = 1'b1;
      if (state_i == PG && cnt_i < CNT_W'(TPGM_MIN))
        short_o = 1'b1;
    end
  end

  assign addr_chg_o = aen_i && aen_q && (addr_i != addr_q);
  assign viol_sum   = {1'b0, viol_q} + 9'(short_o) + 9'(addr_chg_o);

  // Track previous aen/addr and accumulate violations; a new event beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      aen_q  <= 1'b0;
      addr_q <= '0;
      viol_q <= '0;
    end else begin
      aen_q  <= aen_i;
      addr_q <= addr_i;
      if (short_o || addr_chg_o)
        viol_q <= viol_sum[8] ? 8'hFF : viol_sum[7:0];
      else if (err_clr_i)
        viol_q <= '0;
    end
  end

  assign viol_cnt_o = viol_q;

endmodule
`endif

// File: rtl/efuse_macro_emu.sv
// Synthesizable responder model of the 256-bit eFuse macro.
// Optional timing checker enabled by defining EFUSE_EMU_TCHK_EN.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  IDLE    | waiting for an aen rising edge
//  RD      | read pulse in progress, rdata loaded when count == TRD_MIN
//  PG      | program pulse in progress, bit blown at aen fall if long enough
//  WAIT_LO | invalid/no-op access, wait for aen to drop
module efuse_macro_emu
  import efuse_pkg::*;
#(
  parameter int                     TRD_MIN   = 2,
  parameter int                     TPGM_MIN  = 10,
  parameter int                     CNT_W     = 10,
  parameter logic [EFUSE_NBITS-1:0] INIT_FUSE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   efuse_pgmen_i,
  input  logic                   efuse_rden_i,
  input  logic                   efuse_aen_i,
  input  logic [7:0]             efuse_addr_i,
  input  logic                   err_clr_i,
  output logic [7:0]             efuse_rdata_o,
  output logic [EFUSE_NBITS-1:0] fuse_bits_o,
  output logic                   busy_o,
  output logic [7:0]             prog_cnt_o,
  output logic [2:0]             err_o,
  output logic [7:0]             viol_cnt_o
);

  efuse_emu_st_e state_q, state_d;

  logic                   aen_q;
  logic                   aen_rise;
  logic [7:0]             addr_l;
  logic [CNT_W-1:0]       cnt_q;
  logic [EFUSE_NBITS-1:0] fuse_q;
  logic [7:0]             rdata_q;
  logic [7:0]             prog_cnt_q;
  logic [2:0]             err_q;

  logic cnt_load;
  logic cnt_inc;
  logic rd_load;
  logic blow;
  logic conflict;

  logic       tchk_short;
  logic       tchk_addr_chg;
  logic [7:0] tchk_viol_cnt;

  assign aen_rise = efuse_aen_i && !aen_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and per-cycle strobes for the datapath.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    rd_load  = 1'b0;
    blow     = 1'b0;
    conflict = 1'b0;
    case (state_q)
      IDLE: begin
        if (aen_rise) begin
          cnt_load = 1'b1;
          if (efuse_rden_i && !efuse_pgmen_i) begin
            state_d = RD;
          end else if (efuse_pgmen_i && !efuse_rden_i) begin
            state_d = PG;
          end else begin
            conflict = efuse_rden_i && efuse_pgmen_i;
            state_d  = WAIT_LO;
          end
        end
      end
      RD: begin
        // Load on the count match even if this is also the fall edge,
        // so a pulse of exactly TRD_MIN cycles still reads.
        if (cnt_q == CNT_W'(TRD_MIN))
          rd_load = 1'b1;
        if (!efuse_aen_i) state_d = IDLE;
        else              cnt_inc = 1'b1;
      end
      PG: begin
        if (!efuse_aen_i) begin
          blow    = (cnt_q >= CNT_W'(TPGM_MIN));
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!efuse_aen_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // aen edge history, latched access address and pulse-width counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      aen_q  <= 1'b0;
      addr_l <= '0;
      cnt_q  <= '0;
    end else begin
      aen_q <= efuse_aen_i;
      if (state_q == IDLE && aen_rise)
        addr_l <= efuse_addr_i;
      if (cnt_load)
        cnt_q <= CNT_W'(1);
      else if (state_d == IDLE)
        cnt_q <= '0;
      else if (cnt_inc && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fuse storage, read data and successful-program count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fuse_q     <= INIT_FUSE;
      rdata_q    <= '0;
      prog_cnt_q <= '0;
    end else begin
      if (rd_load)
        rdata_q <= fuse_byte(fuse_q, addr_l[4:0]);
      if (blow) begin
        fuse_q[addr_l] <= 1'b1;
        if (prog_cnt_q != 8'hFF)
          prog_cnt_q <= prog_cnt_q + 8'd1;
      end
    end
  end

`ifdef EFUSE_EMU_TCHK_EN
  efuse_emu_tchk #(
    .TRD_MIN  (TRD_MIN),
    .TPGM_MIN (TPGM_MIN),
    .CNT_W    (CNT_W)
  ) u_tchk (
    .clk        (clk),
    .rst        (rst),
    .aen_i      (efuse_aen_i),
    .addr_i     (efuse_addr_i),
    .state_i    (state_q),
    .cnt_i      (cnt_q),
    .err_clr_i  (err_clr_i),
    .short_o    (tchk_short),
    .addr_chg_o (tchk_addr_chg),
    .viol_cnt_o (tchk_viol_cnt)
  );
`else
  assign tchk_short    = 1'b0;
  assign tchk_addr_chg = 1'b0;
  assign tchk_viol_cnt = 8'd0;
`endif

  // Sticky error flags; an event in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q[0] <= conflict      ? 1'b1 : (err_clr_i ? 1'b0 : err_q[0]);
      err_q[1] <= tchk_short    ? 1'b1 : (err_clr_i ? 1'b0 : err_q[1]);
      err_q[2] <= tchk_addr_chg ? 1'b1 : (err_clr_i ? 1'b0 : err_q[2]);
    end
  end

  assign efuse_rdata_o = rdata_q;
  assign fuse_bits_o   = fuse_q;
  assign busy_o        = (state_q != IDLE);
  assign prog_cnt_o    = prog_cnt_q;
  assign err_o         = err_q;
  assign viol_cnt_o    = tchk_viol_cnt;

endmodule
